// File: rtl/gps_time_keeper.sv
// ---------------------------------------------------------------------------
// gps_time_keeper
//
// Keeps PPS-aligned GPS time. Decoded packet time fields are latched into a
// shadow set and loaded (plus one second) on the next synchronised PPS edge.
// When packets stop arriving the calendar is advanced locally (holdover) with
// full month / leap-year rollover, until too many PPS edges pass without a
// packet, at which point time is declared invalid and frozen. A watchdog
// flags a missing PPS. Time, status, control and a missed-PPS counter are
// visible on a small register bus.
//
// Ports:
//   i_clk, i_rst         system clock, asynchronous active-high reset
//   i_pps_raw            raw PPS from the receiver (asynchronous)
//   i_packet_dv          one-cycle strobe, i_year_h..i_seconds valid
//   i_year_h..i_seconds  decoded packet time (year = {i_year_h, i_year_l})
//   i_wr/i_addr/i_data   register write strobe, address, write data
//   o_data               registered read data (valid one cycle after i_addr)
//   o_year_h..o_seconds  current PPS-aligned time
//   o_time_dv            one-cycle pulse when the time outputs update
//   o_time_valid         time is trustworthy
//   o_holdover           time is advanced locally without a fresh packet
//
// Register map (offsets from BASE_ADDR):
//   0..6  year_h, year_l, month, day, hour, minutes, seconds  (RO)
//   7     STATUS: bit0 valid, bit1 holdover, bit2 pps_missing (RO)
//   8     CTRL:   bit0 enable, bit1 clr_missed (write-1 pulse, reads 0)
//   9     MISSED: saturating missed-PPS counter               (RO)
// ---------------------------------------------------------------------------
module gps_time_keeper #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int BASE_ADDR    = 'h20,
  parameter int HOLDOVER_MAX = 60,
  parameter int PPS_TIMEOUT  = 120_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pps_raw,
  input  logic                  i_packet_dv,
  input  logic [DATA_WIDTH-1:0] i_year_h,
  input  logic [DATA_WIDTH-1:0] i_year_l,
  input  logic [DATA_WIDTH-1:0] i_month,
  input  logic [DATA_WIDTH-1:0] i_day,
  input  logic [DATA_WIDTH-1:0] i_hour,
  input  logic [DATA_WIDTH-1:0] i_minutes,
  input  logic [DATA_WIDTH-1:0] i_seconds,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [DATA_WIDTH-1:0] o_year_h,
  output logic [DATA_WIDTH-1:0] o_year_l,
  output logic [DATA_WIDTH-1:0] o_month,
  output logic [DATA_WIDTH-1:0] o_day,
  output logic [DATA_WIDTH-1:0] o_hour,
  output logic [DATA_WIDTH-1:0] o_minutes,
  output logic [DATA_WIDTH-1:0] o_seconds,
  output logic                  o_time_dv,
  output logic                  o_time_valid,
  output logic                  o_holdover
);

  localparam int YW   = 2 * DATA_WIDTH;
  localparam int HC_W = (HOLDOVER_MAX < 1) ? 1 : $clog2(HOLDOVER_MAX + 1);
  localparam int WD_W = (PPS_TIMEOUT < 1) ? 1 : $clog2(PPS_TIMEOUT + 1);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  // Days in a month; the divide-by-4 leap rule is exact for 2000-2099.
  function automatic logic [DATA_WIDTH-1:0] days_in_month(
    input logic [DATA_WIDTH-1:0] month,
    input logic                  leap
  );
    logic [DATA_WIDTH-1:0] d;
    case (int'(month))
      2:           d = leap ? DATA_WIDTH'(29) : DATA_WIDTH'(28);
      4, 6, 9, 11: d = DATA_WIDTH'(30);
      default:     d = DATA_WIDTH'(31);
    endcase
    return d;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // PPS synchroniser and edge detect
  logic pps_meta_p0;
  logic pps_sync_p1;
  logic pps_prev_p2;
  logic pps_edge_p2;

  // Time state
  logic [YW-1:0]         year_q;
  logic [DATA_WIDTH-1:0] month_q, day_q, hour_q, min_q, sec_q;
  logic [YW-1:0]         sh_year;
  logic [DATA_WIDTH-1:0] sh_month, sh_day, sh_hour, sh_min, sh_sec;
  logic                  fresh;

  // Increment datapath
  logic [YW-1:0]         b_year, n_year;
  logic [DATA_WIDTH-1:0] b_month, b_day, b_hour, b_min, b_sec;
  logic [DATA_WIDTH-1:0] n_month, n_day, n_hour, n_min, n_sec;
  logic                  c_min, c_hour, c_day, c_month, c_year;

  // Control / status
  logic                  enable;
  logic                  pps_missing;
  logic [HC_W-1:0]       holdover_cnt;
  logic [DATA_WIDTH-1:0] missed_cnt;
  logic [WD_W-1:0]       watchdog;
  logic                  pps_go, drop, upd, miss;

  // Register bus
  logic [ADDR_WIDTH-1:0] addr_off;
  logic                  addr_hit;
  logic                  ctrl_wr;
  logic                  clr_missed;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_bits;

  assign unused_bits = ^i_data[DATA_WIDTH-1:2];

  // ---- stage p0/p1: two-flop synchroniser; p2: previous-level register ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pps_meta_p0 <= 1'b0;
      pps_sync_p1 <= 1'b0;
      pps_prev_p2 <= 1'b0;
    end else begin
      pps_meta_p0 <= i_pps_raw;
      pps_sync_p1 <= pps_meta_p0;
      pps_prev_p2 <= pps_sync_p1;
    end
  end

  // High during the cycle ending at E2, so the update registers at E2.
  assign pps_edge_p2 = pps_sync_p1 & ~pps_prev_p2;

  // ---- stage p2: update decision and calendar increment ----
  assign pps_go = pps_edge_p2 & enable;
  // The non-fresh edge that would push holdover_cnt past HOLDOVER_MAX.
  assign drop   = ~fresh & o_time_valid & (holdover_cnt == HC_W'(HOLDOVER_MAX));
  assign upd    = pps_go & (fresh | (o_time_valid & ~drop));
  assign miss   = pps_go & ~fresh & o_time_valid;

  always_comb begin
    b_year  = fresh ? sh_year  : year_q;
    b_month = fresh ? sh_month : month_q;
    b_day   = fresh ? sh_day   : day_q;
    b_hour  = fresh ? sh_hour  : hour_q;
    b_min   = fresh ? sh_min   : min_q;
    b_sec   = fresh ? sh_sec   : sec_q;
  end

  always_comb begin
    n_sec   = b_sec;
    n_min   = b_min;
    n_hour  = b_hour;
    n_day   = b_day;
    n_month = b_month;
    n_year  = b_year;
    c_min   = 1'b0;
    c_hour  = 1'b0;
    c_day   = 1'b0;
    c_month = 1'b0;
    c_year  = 1'b0;

    if (b_sec >= DATA_WIDTH'(59)) begin
      n_sec = '0;
      c_min = 1'b1;
    end else begin
      n_sec = b_sec + ONE;
    end

    if (c_min) begin
      if (b_min >= DATA_WIDTH'(59)) begin
        n_min  = '0;
        c_hour = 1'b1;
      end else begin
        n_min = b_min + ONE;
      end
    end

    if (c_hour) begin
      if (b_hour >= DATA_WIDTH'(23)) begin
        n_hour = '0;
        c_day  = 1'b1;
      end else begin
        n_hour = b_hour + ONE;
      end
    end

    if (c_day) begin
      if (b_day >= days_in_month(b_month, b_year[1:0] == 2'b00)) begin
        n_day   = ONE;
        c_month = 1'b1;
      end else begin
        n_day = b_day + ONE;
      end
    end

    if (c_month) begin
      if (b_month >= DATA_WIDTH'(12)) begin
        n_month = ONE;
        c_year  = 1'b1;
      end else begin
        n_month = b_month + ONE;
      end
    end

    if (c_year) begin
      n_year = b_year + YW'(1);
    end
  end

  // ---- stage p3: time outputs, shadow capture, validity ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      year_q       <= '0;
      month_q      <= ONE;
      day_q        <= ONE;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      o_time_dv    <= 1'b0;
      sh_year      <= '0;
      sh_month     <= '0;
      sh_day       <= '0;
      sh_hour      <= '0;
      sh_min       <= '0;
      sh_sec       <= '0;
      fresh        <= 1'b0;
      o_time_valid <= 1'b0;
      o_holdover   <= 1'b0;
      holdover_cnt <= '0;
    end else begin
      o_time_dv <= upd;
      if (upd) begin
        year_q  <= n_year;
        month_q <= n_month;
        day_q   <= n_day;
        hour_q  <= n_hour;
        min_q   <= n_min;
        sec_q   <= n_sec;
      end

      // A packet landing on the PPS cycle is kept for the next edge.
      if (i_packet_dv) begin
        sh_year  <= {i_year_h, i_year_l};
        sh_month <= i_month;
        sh_day   <= i_day;
        sh_hour  <= i_hour;
        sh_min   <= i_minutes;
        sh_sec   <= i_seconds;
        fresh    <= 1'b1;
      end else if (pps_go) begin
        fresh <= 1'b0;
      end

      if (pps_go) begin
        if (fresh) begin
          o_time_valid <= 1'b1;
          o_holdover   <= 1'b0;
          holdover_cnt <= '0;
        end else if (o_time_valid) begin
          if (drop) begin
            o_time_valid <= 1'b0;
            o_holdover   <= 1'b0;
            holdover_cnt <= '0;
          end else begin
            o_holdover   <= 1'b1;
            holdover_cnt <= holdover_cnt + HC_W'(1);
          end
        end
      end
    end
  end

  assign o_year_h  = year_q[YW-1:DATA_WIDTH];
  assign o_year_l  = year_q[DATA_WIDTH-1:0];
  assign o_month   = month_q;
  assign o_day     = day_q;
  assign o_hour    = hour_q;
  assign o_minutes = min_q;
  assign o_seconds = sec_q;

  // ---- PPS watchdog ----
  // Watches the synchronised edge regardless of enable: it reports whether
  // the receiver is producing PPS at all.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      watchdog    <= '0;
      pps_missing <= 1'b0;
    end else if (pps_edge_p2) begin
      watchdog    <= '0;
      pps_missing <= 1'b0;
    end else if (!pps_missing) begin
      if (watchdog >= WD_W'(PPS_TIMEOUT - 1)) begin
        watchdog    <= WD_W'(PPS_TIMEOUT);
        pps_missing <= 1'b1;
      end else begin
        watchdog <= watchdog + WD_W'(1);
      end
    end
  end

  // ---- register bus ----
  assign addr_off   = i_addr - ADDR_WIDTH'(BASE_ADDR);
  assign addr_hit   = (i_addr >= ADDR_WIDTH'(BASE_ADDR)) && (addr_off <= ADDR_WIDTH'(9));
  assign ctrl_wr    = i_wr & addr_hit & (addr_off == ADDR_WIDTH'(8));
  assign clr_missed = ctrl_wr & i_data[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      enable     <= 1'b1;
      missed_cnt <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= i_data[0];
      end
      // Clear has priority over a coincident missed-PPS increment.
      if (clr_missed) begin
        missed_cnt <= '0;
      end else if (miss) begin
        missed_cnt <= sat_inc(missed_cnt);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (addr_hit) begin
      case (int'(addr_off))
        0:       rd_mux = year_q[YW-1:DATA_WIDTH];
        1:       rd_mux = year_q[DATA_WIDTH-1:0];
        2:       rd_mux = month_q;
        3:       rd_mux = day_q;
        4:       rd_mux = hour_q;
        5:       rd_mux = min_q;
        6:       rd_mux = sec_q;
        7:       rd_mux = DATA_WIDTH'({pps_missing, o_holdover, o_time_valid});
        8:       rd_mux = DATA_WIDTH'(enable);
        9:       rd_mux = missed_cnt;
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
    end else begin
      o_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gps_time_keeper.sv
module tb_gps_time_keeper;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int BASE = 'h20;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  min;
    logic [7:0]  sec;
  } tm_t;

  typedef struct {
    tm_t pkt;
    tm_t exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pps_raw;
  logic          packet_dv;
  logic [DW-1:0] year_h, year_l, month, day, hour, minutes, seconds;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] o_data;
  logic [DW-1:0] o_year_h, o_year_l, o_month, o_day, o_hour, o_minutes, o_seconds;
  logic          o_time_dv, o_time_valid, o_holdover;

  int  checks = 0;
  int  errors = 0;
  tm_t exp_q[$];

  gps_time_keeper #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (BASE),
    .HOLDOVER_MAX(4),
    .PPS_TIMEOUT (100)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pps_raw   (pps_raw),
    .i_packet_dv (packet_dv),
    .i_year_h    (year_h),
    .i_year_l    (year_l),
    .i_month     (month),
    .i_day       (day),
    .i_hour      (hour),
    .i_minutes   (minutes),
    .i_seconds   (seconds),
    .i_wr        (wr),
    .i_addr      (addr),
    .i_data      (wdata),
    .o_data      (o_data),
    .o_year_h    (o_year_h),
    .o_year_l    (o_year_l),
    .o_month     (o_month),
    .o_day       (o_day),
    .o_hour      (o_hour),
    .o_minutes   (o_minutes),
    .o_seconds   (o_seconds),
    .o_time_dv   (o_time_dv),
    .o_time_valid(o_time_valid),
    .o_holdover  (o_holdover)
  );

  always #5 clk = ~clk;

  function automatic tm_t mk(input int y, input int mo, input int d,
                             input int h, input int mi, input int s);
    tm_t t;
    t.year  = 16'(y);
    t.month = 8'(mo);
    t.day   = 8'(d);
    t.hour  = 8'(h);
    t.min   = 8'(mi);
    t.sec   = 8'(s);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_fields(input tm_t t);
    year_h  = t.year[15:8];
    year_l  = t.year[7:0];
    month   = t.month;
    day     = t.day;
    hour    = t.hour;
    minutes = t.min;
    seconds = t.sec;
  endtask

  task automatic send_pkt(input tm_t t);
    @(negedge clk);
    load_fields(t);
    packet_dv = 1'b1;
    @(negedge clk);
    packet_dv = 1'b0;
  endtask

  // Raw PPS goes high before E0; optionally a packet is presented so that
  // it is sampled at E2, the same edge that applies the PPS update.
  task automatic do_pps(input bit with_pkt, input tm_t t);
    @(negedge clk);
    pps_raw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (with_pkt) begin
      load_fields(t);
      packet_dv = 1'b1;
    end
    @(negedge clk);
    packet_dv = 1'b0;
    @(negedge clk);
    pps_raw = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input int off, output logic [DW-1:0] d);
    @(negedge clk);
    addr = AW'(BASE + off);
    @(negedge clk);
    d = o_data;
  endtask

  task automatic wr_reg(input int off, input logic [DW-1:0] d);
    @(negedge clk);
    addr  = AW'(BASE + off);
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Scoreboard: every o_time_dv pulse pops one expected time.
  initial begin : monitor
    logic prev_dv;
    tm_t  act;
    tm_t  e;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dv = 1'b0;
      end else begin
        if (o_time_dv) begin
          checks++;
          if (prev_dv) begin
            errors++;
            $display("FAIL dv_width: got 2 cycles required 1");
          end
          act.year  = {o_year_h, o_year_l};
          act.month = o_month;
          act.day   = o_day;
          act.hour  = o_hour;
          act.min   = o_minutes;
          act.sec   = o_seconds;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL dv_unexpected: got pulse with time %0d-%0d-%0d %0d:%0d:%0d required none",
                     act.year, act.month, act.day, act.hour, act.min, act.sec);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              errors++;
              $display("FAIL time_out: got %0d-%0d-%0d %0d:%0d:%0d required %0d-%0d-%0d %0d:%0d:%0d",
                       act.year, act.month, act.day, act.hour, act.min, act.sec,
                       e.year, e.month, e.day, e.hour, e.min, e.sec);
            end
          end
        end
        prev_dv = o_time_dv;
      end
    end
  end

  initial begin : timeout
    #200_000;
    $display("FAIL timeout: got no finish required finish within 200us");
    $fatal(1);
  end

  initial begin : stim
    vec_t          vecs[7];
    logic [DW-1:0] d;
    tm_t           none;
    logic [DW-1:0] rst_exp[10];

    vecs[0] = '{mk(2024, 2, 28, 23, 59, 59), mk(2024, 2, 29, 0, 0, 0)};
    vecs[1] = '{mk(2023, 12, 31, 23, 59, 59), mk(2024, 1, 1, 0, 0, 0)};
    vecs[2] = '{mk(2023, 2, 28, 23, 59, 59), mk(2023, 3, 1, 0, 0, 0)};
    vecs[3] = '{mk(2024, 4, 30, 23, 59, 59), mk(2024, 5, 1, 0, 0, 0)};
    vecs[4] = '{mk(2024, 1, 31, 10, 59, 59), mk(2024, 1, 31, 11, 0, 0)};
    vecs[5] = '{mk(2025, 6, 15, 8, 30, 7), mk(2025, 6, 15, 8, 30, 8)};
    vecs[6] = '{mk(2024, 2, 29, 23, 59, 59), mk(2024, 3, 1, 0, 0, 0)};
    rst_exp = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    none    = '0;

    rst       = 1'b1;
    pps_raw   = 1'b0;
    packet_dv = 1'b0;
    wr        = 1'b0;
    addr      = '0;
    wdata     = '0;
    load_fields(none);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state through the register bus
    check("rst_valid", 32'(o_time_valid), 32'd0);
    check("rst_holdover", 32'(o_holdover), 32'd0);
    for (int i = 0; i < 10; i++) begin
      rd(i, d);
      check($sformatf("rst_reg%0d", i), 32'(d), 32'(rst_exp[i]));
    end
    rd(-1, d);
    check("unmapped_lo", 32'(d), 32'd0);
    rd(10, d);
    check("unmapped_hi", 32'(d), 32'd0);

    // Fresh packet per PPS, calendar rollovers
    for (int i = 0; i < 7; i++) begin
      send_pkt(vecs[i].pkt);
      exp_q.push_back(vecs[i].exp);
      do_pps(1'b0, none);
      check($sformatf("vec%0d_drain", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("vec%0d_valid", i), 32'(o_time_valid), 32'd1);
      check($sformatf("vec%0d_holdover", i), 32'(o_holdover), 32'd0);
    end

    // Holdover for three PPS, then clear MISSED
    send_pkt(mk(2024, 3, 10, 12, 0, 0));
    exp_q.push_back(mk(2024, 3, 10, 12, 0, 1));
    do_pps(1'b0, none);
    for (int k = 2; k <= 4; k++) begin
      exp_q.push_back(mk(2024, 3, 10, 12, 0, k));
      do_pps(1'b0, none);
    end
    check("ho_drain", 32'(exp_q.size()), 32'd0);
    check("ho_holdover", 32'(o_holdover), 32'd1);
    check("ho_valid", 32'(o_time_valid), 32'd1);
    rd(9, d);
    check("ho_missed", 32'(d), 32'd3);
    rd(7, d);
    check("ho_status", 32'(d), 32'h03);
    wr_reg(8, 8'h03);
    rd(9, d);
    check("clr_missed", 32'(d), 32'd0);
    rd(8, d);
    check("ctrl_after_clr", 32'(d), 32'h01);

    // Holdover limit: fifth non-fresh PPS invalidates and freezes
    send_pkt(mk(2024, 3, 10, 12, 0, 0));
    exp_q.push_back(mk(2024, 3, 10, 12, 0, 1));
    do_pps(1'b0, none);
    for (int k = 2; k <= 5; k++) begin
      exp_q.push_back(mk(2024, 3, 10, 12, 0, k));
      do_pps(1'b0, none);
    end
    check("homax_valid_before", 32'(o_time_valid), 32'd1);
    do_pps(1'b0, none);
    check("homax_valid", 32'(o_time_valid), 32'd0);
    check("homax_holdover", 32'(o_holdover), 32'd0);
    check("homax_freeze_sec", 32'(o_seconds), 32'd5);
    do_pps(1'b0, none);
    check("homax_freeze_sec2", 32'(o_seconds), 32'd5);
    check("homax_drain", 32'(exp_q.size()), 32'd0);

    // Packet on the PPS cycle: old time + 1 now, new packet + 1 next
    send_pkt(mk(2024, 7, 4, 10, 0, 0));
    exp_q.push_back(mk(2024, 7, 4, 10, 0, 1));
    do_pps(1'b0, none);
    exp_q.push_back(mk(2024, 7, 4, 10, 0, 2));
    do_pps(1'b1, mk(2024, 7, 4, 20, 0, 0));
    check("same_holdover", 32'(o_holdover), 32'd1);
    exp_q.push_back(mk(2024, 7, 4, 20, 0, 1));
    do_pps(1'b0, none);
    check("same_drain", 32'(exp_q.size()), 32'd0);
    check("same_fresh_holdover", 32'(o_holdover), 32'd0);

    // PPS watchdog
    repeat (110) @(negedge clk);
    rd(7, d);
    check("wd_status_missing", 32'(d), 32'h05);
    exp_q.push_back(mk(2024, 7, 4, 20, 0, 2));
    do_pps(1'b0, none);
    rd(7, d);
    check("wd_status_cleared", 32'(d), 32'h03);

    // Disabled: PPS ignored
    wr_reg(8, 8'h00);
    rd(8, d);
    check("ctrl_disabled", 32'(d), 32'h00);
    do_pps(1'b0, none);
    check("dis_sec", 32'(o_seconds), 32'd2);
    check("dis_drain", 32'(exp_q.size()), 32'd0);
    wr_reg(8, 8'h01);

    // Asynchronous reset mid-operation
    @(negedge clk);
    pps_raw = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_month", 32'(o_month), 32'd1);
    check("arst_sec", 32'(o_seconds), 32'd0);
    check("arst_year_l", 32'(o_year_l), 32'd0);
    check("arst_valid", 32'(o_time_valid), 32'd0);
    pps_raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(8, d);
    check("arst_ctrl", 32'(d), 32'h01);
    rd(7, d);
    check("arst_status", 32'(d), 32'h00);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_time_keeper.md
Name: gps_time_keeper

Overview:
Parametrised successor to the Thunderbolt time path. It latches decoded GPS packet time fields and aligns them to the synchronised PPS edge. When packets stop arriving it keeps time locally in holdover, advancing the calendar by one second per PPS with full month/leap-year rollover. It also runs a PPS watchdog and exposes time, status, control and an error counter on the shared register bus.

Parameters:
DATA_WIDTH, 8, width of the register bus and of each time field.
ADDR_WIDTH, 8, width of the register address.
BASE_ADDR, 8'h20, address of register offset 0.
HOLDOVER_MAX, 60, consecutive PPS edges without a fresh packet before time is declared invalid.
PPS_TIMEOUT, 120_000_000, i_clk cycles without a PPS edge before the pps_missing flag sets.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_pps_raw  in  1  raw PPS from the receiver (asynchronous to i_clk)
i_packet_dv  in  1  one-cycle pulse; the i_* time fields below are valid
i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds  in  DATA_WIDTH each  decoded packet time; year = {i_year_h, i_year_l}
i_wr  in  1  register write strobe
i_addr  in  ADDR_WIDTH  register address
i_data  in  DATA_WIDTH  register write data
o_data  out  DATA_WIDTH  register read data
o_year_h, o_year_l, o_month, o_day, o_hour, o_minutes, o_seconds  out  DATA_WIDTH each  current PPS-aligned time
o_time_dv  out  1  one-cycle pulse when the o_* time fields update
o_time_valid  out  1  time is trustworthy
o_holdover  out  1  time is being advanced locally, without a fresh packet

Behaviour:
- Reset: asynchronous, active-high. Reset values:
  - o_year_h/l, o_hour, o_minutes, o_seconds, o_data: 0.
  - o_month, o_day: 1.
  - o_time_dv, o_time_valid, o_holdover: 0.
  - shadow registers and fresh flag: cleared. holdover_cnt, missed_cnt, watchdog: cleared.
  - enable = 1. pps_missing = 0.
  - Reset asserted mid-operation aborts everything; there is no partial update.
- PPS path:
  - i_pps_raw passes through a 2-FF synchroniser, then a registered rising-edge detect.
  - Define E0 as the first i_clk edge that samples i_pps_raw high. The time outputs and o_time_dv register at E2.
  - A PPS edge is ignored (no update, no counter activity) while enable = 0.
- Packet capture:
  - On i_packet_dv, all seven fields are copied into shadow registers and fresh is set.
- On a PPS edge (enable = 1):
  - Base time: the shadow if fresh = 1, otherwise the current outputs.
  - Outputs <= base + 1 s.
  - fresh is cleared.
  - o_time_dv pulses for exactly one cycle.
  - If fresh = 0 and o_time_valid = 0, nothing updates and o_time_dv stays low.
- Packet and PPS in the same cycle: the packet is captured, and its fresh flag applies to the NEXT PPS. The current update uses the old shadow/fresh state.
- Calendar increment (year range 2000–2099; the divide-by-4 leap rule is exact in that range):
  - seconds 59 -> 0 carries to minutes; minutes 59 -> 0 carries to hours; hours 23 -> 0 carries to day.
  - Day wraps to 1 after 31/30/28/29 according to month and leap year; month 12 -> 1 carries to year.
  - Year is a 2*DATA_WIDTH increment that wraps at all-ones.
- Validity and holdover:
  - A fresh PPS update sets o_time_valid = 1 and o_holdover = 0, and clears holdover_cnt.
  - A non-fresh update while valid sets o_holdover = 1 and increments holdover_cnt and missed_cnt.
  - When holdover_cnt would exceed HOLDOVER_MAX: o_time_valid = 0 and o_holdover = 0. The time outputs freeze at the last value.
- Watchdog:
  - Counts i_clk cycles since the last PPS edge and clears on every edge.
  - When it reaches PPS_TIMEOUT, pps_missing sets and the counter saturates.
  - pps_missing clears on the next PPS edge.
- Register map (offsets from BASE_ADDR):
  - +0..+6: year_h, year_l, month, day, hour, minutes, seconds (read-only).
  - +7 STATUS (read-only): bit0 valid, bit1 holdover, bit2 pps_missing.
  - +8 CTRL (read/write): bit0 enable; bit1 clr_missed, write-1 self-clearing, reads 0.
  - +9 MISSED (read-only): missed_cnt, saturating at all-ones.
- Register bus rules:
  - Reads are registered: o_data is valid the cycle after i_addr is presented. Unmapped addresses read 0.
  - Writes to read-only registers are ignored.
  - If clr_missed coincides with a missed-PPS increment, the clear wins.

Test Plan:
- Reset, then read +0..+9 -> outputs 0 except month = 1, day = 1; CTRL = 0x01; STATUS = 0x00; o_time_dv never pulses without a packet.
- Packet 2024-02-28 23:59:59, then PPS -> at E2: 2024-02-29 00:00:00, o_time_dv one cycle, valid = 1, holdover = 0.
- Packet 2023-12-31 23:59:59, then PPS -> 2024-01-01 00:00:00. Separately, packet 2023-02-28 23:59:59 -> 2023-03-01.
- One fresh packet, then 3 PPS without packets -> seconds advance by 3, holdover = 1, MISSED = 3. Write CTRL = 0x03 -> MISSED = 0.
- Fresh packet, then HOLDOVER_MAX+1 non-fresh PPS (HOLDOVER_MAX = 4 in bench) -> valid drops on the 5th, outputs freeze, o_time_dv stays low afterwards.
- i_packet_dv in the same cycle as the synchronised PPS edge -> that update uses the old time + 1; the next PPS loads the new packet + 1. PPS withheld for PPS_TIMEOUT cycles (bench = 100) -> STATUS bit2 = 1, cleared at the next PPS.
